// File: rtl/redmule_qint_unpack_pkg.sv
// ---------------------------------------------------------------------------
// redmule_pkg
// Shared types for the RedMulE weight path.
//   DATA_W         default stream data width in bits
//   qint_fmt_e     quantized weight format (8, 4 or 2 bits per element)
//   unpack_state_e EMPTY / HOLD state of the qint unpacker
//   qint_beats()   number of output beats one packed word expands into
// ---------------------------------------------------------------------------
package redmule_pkg;

    localparam int unsigned DATA_W = 256;

    typedef enum logic [1:0] {
        QINT_8 = 2'd0,
        QINT_4 = 2'd1,
        QINT_2 = 2'd2
    } qint_fmt_e;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } unpack_state_e;

    // Narrower elements pack more of them per word, so the word takes more
    // beats to drain. The unused encoding falls back to the 8-bit behaviour.
    function automatic logic [2:0] qint_beats(input qint_fmt_e fmt);
        case (fmt)
            QINT_4:  qint_beats = 3'd2;
            QINT_2:  qint_beats = 3'd4;
            default: qint_beats = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/redmule_qint_unpack_if.sv
// ---------------------------------------------------------------------------
// hwpe_stream_intf_stream
// Valid/ready stream carrying a data word and its byte strobes.
//   valid  producer has a beat on data/strb
//   ready  consumer takes the beat when valid && ready at a rising edge
//   data   DATA_WIDTH payload bits
//   strb   one strobe bit per payload byte
// Modports: source (producer side), sink (consumer side).
// ---------------------------------------------------------------------------
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                      valid;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH/8-1:0]   strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/redmule_qint_unpack.sv
// ---------------------------------------------------------------------------
// redmule_qint_unpack
// Splits densely packed quantized weight words into per-beat slices that
// each carry DW/8 elements in the low bits, ready for the qint cast stage.
// An 8-bit word passes through in one beat, a 4-bit word in two, a 2-bit
// word in four.
//   clk_i     clock, rising edge
//   rst_ni    synchronous active-low reset
//   clear_i   synchronous soft clear, drops the word in flight
//   fmt_i     weight format, sampled when a word is accepted
//   stream_i  packed input words (sink)
//   stream_o  unpacked beats (source)
// ---------------------------------------------------------------------------
module redmule_qint_unpack
    import redmule_pkg::*;
#(
    parameter int unsigned DW = DATA_W
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  qint_fmt_e                     fmt_i,
    hwpe_stream_intf_stream.sink          stream_i,
    hwpe_stream_intf_stream.source        stream_o
);

    localparam int unsigned SB = DW / 8;
    localparam int unsigned IW = $clog2(SB);

    unpack_state_e  state_q;
    logic [DW-1:0]  data_q;
    logic [SB-1:0]  strb_q;
    qint_fmt_e      fmt_q;
    logic [1:0]     k_q;

    logic           full;
    logic           last_beat;
    logic           in_ready;
    logic [2:0]     beats;
    logic [1:0]     shift;
    logic [DW-1:0]  out_data;
    logic [SB-1:0]  out_strb;

    assign full      = (state_q == HOLD);
    assign beats     = qint_beats(fmt_q);
    assign last_beat = ({1'b0, k_q} == (beats - 3'd1));

    // A new word is taken only when nothing is held or the last beat of the
    // held word leaves this cycle, so the output never bubbles between words.
    assign in_ready = !clear_i && (!full || (stream_o.ready && last_beat));

    assign stream_i.ready = in_ready;
    assign stream_o.valid = full;
    assign stream_o.data  = out_data;
    assign stream_o.strb  = out_strb;

    // log2 of the beat count: maps an output strobe position onto the byte
    // of the packed word that holds that element.
    always_comb begin
        shift = 2'd0;
        case (fmt_q)
            QINT_4:  shift = 2'd1;
            QINT_2:  shift = 2'd2;
            default: shift = 2'd0;
        endcase
    end

    // Slice k of the held word lands in the low bits, upper bits stay zero.
    always_comb begin
        out_data = '0;
        case (fmt_q)
            QINT_4: begin
                if (k_q[0]) out_data[DW/2-1:0] = data_q[DW-1:DW/2];
                else        out_data[DW/2-1:0] = data_q[DW/2-1:0];
            end
            QINT_2: begin
                case (k_q)
                    2'd0:    out_data[DW/4-1:0] = data_q[DW/4-1:0];
                    2'd1:    out_data[DW/4-1:0] = data_q[DW/2-1:DW/4];
                    2'd2:    out_data[DW/4-1:0] = data_q[3*DW/4-1:DW/2];
                    default: out_data[DW/4-1:0] = data_q[DW-1:3*DW/4];
                endcase
            end
            default: out_data = data_q;
        endcase
    end

    // Each output element inherits the strobe of the input byte it came from.
    always_comb begin
        out_strb = '0;
        for (int j = 0; j < SB; j++) begin
            out_strb[j] = strb_q[IW'((32'(k_q) * SB + 32'(j)) >> shift)];
        end
    end

    // Reset outranks clear, clear outranks every handshake. Otherwise a word
    // is captured on input acceptance, or the beat counter advances when the
    // consumer takes a beat.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            data_q  <= '0;
            strb_q  <= '0;
            fmt_q   <= QINT_8;
            k_q     <= 2'd0;
        end else if (clear_i) begin
            state_q <= EMPTY;
            data_q  <= '0;
            strb_q  <= '0;
            k_q     <= 2'd0;
        end else if (stream_i.valid && in_ready) begin
            state_q <= HOLD;
            data_q  <= stream_i.data;
            strb_q  <= stream_i.strb;
            fmt_q   <= fmt_i;
            k_q     <= 2'd0;
        end else if (full && stream_o.ready) begin
            if (last_beat) begin
                state_q <= EMPTY;
                k_q     <= 2'd0;
            end else begin
                k_q     <= k_q + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_redmule_qint_unpack.sv
// ---------------------------------------------------------------------------
// tb_redmule_qint_unpack
// Directed scenarios for the qint unpacker at DW=256: pass-through of 8-bit
// words, 4-bit and 2-bit slicing, strobe expansion, consumer stalls, format
// change mid-word, soft clear and reset of a word in flight.
// ---------------------------------------------------------------------------
module tb_redmule_qint_unpack;
    import redmule_pkg::*;

    localparam int unsigned DW = 256;
    localparam int unsigned SB = DW / 8;

    logic      clk;
    logic      rst_n;
    logic      clear;
    qint_fmt_e fmt;

    int checks;
    int errors;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) in_if ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) out_if ();

    redmule_qint_unpack #(.DW(DW)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clear_i  (clear),
        .fmt_i    (fmt),
        .stream_i (in_if),
        .stream_o (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bounds the whole run in case the design locks up.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        fmt = QINT_2;
        in_if.valid = 1'b1;
        in_if.data = {DW{1'b1}};
        in_if.strb = '1;
        out_if.ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid got=%b exp=0", out_if.valid);
        end
        checks++;
        if (out_if.data !== '0) begin
            errors++; $display("[TB] FAIL reset_data got=%h exp=0", out_if.data);
        end
        checks++;
        if (out_if.strb !== '0) begin
            errors++; $display("[TB] FAIL reset_strb got=%h exp=0", out_if.strb);
        end
        in_if.valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_qint8();
        logic [DW-1:0] wa, wb;
        wa = {32{8'hA5}};
        wb = {32{8'h5A}};
        fmt = QINT_8;
        in_if.data = wa;
        in_if.strb = '1;
        in_if.valid = 1'b1;
        out_if.ready = 1'b1;
        #1;
        checks++;
        if (in_if.ready !== 1'b1) begin
            errors++; $display("[TB] FAIL q8_ready_empty got=%b exp=1", in_if.ready);
        end
        tick();
        checks++;
        if (out_if.valid !== 1'b1) begin
            errors++; $display("[TB] FAIL q8_latency_valid got=%b exp=1", out_if.valid);
        end
        checks++;
        if (out_if.data !== wa) begin
            errors++; $display("[TB] FAIL q8_data0 got=%h exp=%h", out_if.data, wa);
        end
        checks++;
        if (out_if.strb !== {SB{1'b1}}) begin
            errors++; $display("[TB] FAIL q8_strb got=%h exp=ffffffff", out_if.strb);
        end
        in_if.data = wb;
        #1;
        checks++;
        if (in_if.ready !== 1'b1) begin
            errors++; $display("[TB] FAIL q8_ready_hold got=%b exp=1", in_if.ready);
        end
        tick();
        checks++;
        if (out_if.data !== wb) begin
            errors++; $display("[TB] FAIL q8_data1 got=%h exp=%h", out_if.data, wb);
        end
        in_if.valid = 1'b0;
        tick();
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL q8_drain_valid got=%b exp=0", out_if.valid);
        end
    endtask

    task automatic test_qint4();
        logic [DW-1:0] w, w2;
        for (int i = 0; i < 64; i++) w[i*4 +: 4] = 4'(i % 16);
        w2 = ~w;
        fmt = QINT_4;
        in_if.data = w;
        in_if.strb = '1;
        in_if.valid = 1'b1;
        out_if.ready = 1'b1;
        tick();
        in_if.data = w2;
        #1;
        checks++;
        if (out_if.data !== {128'd0, w[127:0]}) begin
            errors++; $display("[TB] FAIL q4_beat0 got=%h exp=%h", out_if.data, {128'd0, w[127:0]});
        end
        checks++;
        if (out_if.strb !== {SB{1'b1}}) begin
            errors++; $display("[TB] FAIL q4_strb0 got=%h exp=ffffffff", out_if.strb);
        end
        checks++;
        if (in_if.ready !== 1'b0) begin
            errors++; $display("[TB] FAIL q4_ready_k0 got=%b exp=0", in_if.ready);
        end
        tick();
        checks++;
        if (out_if.data !== {128'd0, w[255:128]}) begin
            errors++; $display("[TB] FAIL q4_beat1 got=%h exp=%h", out_if.data, {128'd0, w[255:128]});
        end
        checks++;
        if (in_if.ready !== 1'b1) begin
            errors++; $display("[TB] FAIL q4_ready_k1 got=%b exp=1", in_if.ready);
        end
        tick();
        in_if.valid = 1'b0;
        checks++;
        if (out_if.valid !== 1'b1 || out_if.data !== {128'd0, w2[127:0]}) begin
            errors++; $display("[TB] FAIL q4_no_bubble got=%b/%h exp=1/%h", out_if.valid, out_if.data, {128'd0, w2[127:0]});
        end
        tick();
        checks++;
        if (out_if.data !== {128'd0, w2[255:128]}) begin
            errors++; $display("[TB] FAIL q4_w2_beat1 got=%h exp=%h", out_if.data, {128'd0, w2[255:128]});
        end
        tick();
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL q4_drain_valid got=%b exp=0", out_if.valid);
        end
    endtask

    task automatic test_qint2_strb();
        logic [DW-1:0] x;
        logic [SB-1:0] exp_strb;
        for (int i = 0; i < 8; i++) x[i*32 +: 32] = 32'h1000_0001 * (i + 1);
        fmt = QINT_2;
        in_if.data = x;
        in_if.strb = 32'h0000_00FF;
        in_if.valid = 1'b1;
        out_if.ready = 1'b1;
        tick();
        in_if.valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_strb = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
            checks++;
            if (out_if.data !== {192'd0, x[k*64 +: 64]}) begin
                errors++; $display("[TB] FAIL q2_data_k%0d got=%h exp=%h", k, out_if.data, {192'd0, x[k*64 +: 64]});
            end
            checks++;
            if (out_if.strb !== exp_strb) begin
                errors++; $display("[TB] FAIL q2_strb_k%0d got=%h exp=%h", k, out_if.strb, exp_strb);
            end
            checks++;
            if (in_if.ready !== (k == 3)) begin
                errors++; $display("[TB] FAIL q2_ready_k%0d got=%b exp=%b", k, in_if.ready, (k == 3));
            end
            tick();
        end
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL q2_drain_valid got=%b exp=0", out_if.valid);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] words [2];
        logic [DW-1:0] exp_beats [4];
        logic exp_rdy, in_fire, out_fire, m_full, k_m;
        int beat, wi;
        words[0] = {8{32'hDEAD_BEEF}};
        words[1] = {8{32'h0123_4567}};
        for (int b = 0; b < 4; b++) exp_beats[b] = {128'd0, words[b/2][(b%2)*128 +: 128]};
        beat = 0;
        wi = 0;
        m_full = 1'b0;
        fmt = QINT_4;
        in_if.strb = '1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            out_if.ready = (cyc % 2 == 0);
            in_if.valid = (wi < 2);
            in_if.data = (wi < 2) ? words[wi] : '0;
            #1;
            k_m = (beat % 2 == 1);
            exp_rdy = !m_full || (out_if.ready && k_m);
            checks++;
            if (out_if.valid !== m_full) begin
                errors++; $display("[TB] FAIL stall_valid_c%0d got=%b exp=%b", cyc, out_if.valid, m_full);
            end
            checks++;
            if (in_if.ready !== exp_rdy) begin
                errors++; $display("[TB] FAIL stall_ready_c%0d got=%b exp=%b", cyc, in_if.ready, exp_rdy);
            end
            if (m_full && beat < 4) begin
                checks++;
                if (out_if.data !== exp_beats[beat]) begin
                    errors++; $display("[TB] FAIL stall_data_c%0d got=%h exp=%h", cyc, out_if.data, exp_beats[beat]);
                end
            end
            in_fire = in_if.valid && exp_rdy;
            out_fire = m_full && out_if.ready;
            if (out_fire) begin
                beat++;
                if (k_m) m_full = in_fire;
            end else if (!m_full) begin
                m_full = in_fire;
            end
            if (in_fire) wi++;
            tick();
        end
        in_if.valid = 1'b0;
        out_if.ready = 1'b1;
        checks++;
        if (beat != 4 || wi != 2) begin
            errors++; $display("[TB] FAIL stall_count got=%0d/%0d exp=4/2", beat, wi);
        end
    endtask

    task automatic test_fmt_switch();
        logic [DW-1:0] y, z;
        y = {4{64'hFEDC_BA98_7654_3210}} ^ {64'h1, 64'h2, 64'h3, 64'h4};
        z = {16{16'hC3A1}};
        fmt = QINT_2;
        in_if.data = y;
        in_if.strb = '1;
        in_if.valid = 1'b1;
        out_if.ready = 1'b1;
        tick();
        fmt = QINT_8;
        in_if.data = z;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_if.valid !== 1'b1 || out_if.data !== {192'd0, y[k*64 +: 64]}) begin
                errors++; $display("[TB] FAIL fmt_old_k%0d got=%b/%h exp=1/%h", k, out_if.valid, out_if.data, {192'd0, y[k*64 +: 64]});
            end
            tick();
        end
        in_if.valid = 1'b0;
        checks++;
        if (out_if.data !== z) begin
            errors++; $display("[TB] FAIL fmt_new_data got=%h exp=%h", out_if.data, z);
        end
        tick();
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL fmt_new_single_beat got=%b exp=0", out_if.valid);
        end
    endtask

    task automatic test_clear_reset();
        logic [DW-1:0] c1, c2;
        c1 = {8{32'hAAAA_5555}} ^ {32'h1, 224'd0};
        c2 = {8{32'h0F0F_3C3C}};
        fmt = QINT_2;
        in_if.strb = '1;
        out_if.ready = 1'b1;
        // Soft clear while the second beat is on the output.
        in_if.data = c1;
        in_if.valid = 1'b1;
        tick();
        in_if.valid = 1'b0;
        tick();
        checks++;
        if (out_if.valid !== 1'b1 || out_if.data !== {192'd0, c1[127:64]}) begin
            errors++; $display("[TB] FAIL clr_k1 got=%b/%h exp=1/%h", out_if.valid, out_if.data, {192'd0, c1[127:64]});
        end
        clear = 1'b1;
        #1;
        checks++;
        if (in_if.ready !== 1'b0) begin
            errors++; $display("[TB] FAIL clr_ready got=%b exp=0", in_if.ready);
        end
        tick();
        clear = 1'b0;
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL clr_valid got=%b exp=0", out_if.valid);
        end
        in_if.data = c2;
        in_if.valid = 1'b1;
        tick();
        in_if.valid = 1'b0;
        checks++;
        if (out_if.data !== {192'd0, c2[63:0]}) begin
            errors++; $display("[TB] FAIL clr_restart got=%h exp=%h", out_if.data, {192'd0, c2[63:0]});
        end
        repeat (4) tick();
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL clr_drain got=%b exp=0", out_if.valid);
        end
        // Same again with reset instead of clear.
        in_if.data = c1;
        in_if.valid = 1'b1;
        tick();
        in_if.valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (out_if.valid !== 1'b0 || out_if.data !== '0 || out_if.strb !== '0) begin
            errors++; $display("[TB] FAIL rst_flight got=%b/%h/%h exp=0/0/0", out_if.valid, out_if.data, out_if.strb);
        end
        rst_n = 1'b1;
        in_if.data = c2;
        in_if.valid = 1'b1;
        tick();
        in_if.valid = 1'b0;
        checks++;
        if (out_if.data !== {192'd0, c2[63:0]}) begin
            errors++; $display("[TB] FAIL rst_restart got=%h exp=%h", out_if.data, {192'd0, c2[63:0]});
        end
        repeat (4) tick();
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_drain got=%b exp=0", out_if.valid);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_qint8();
        test_qint4();
        test_qint2_strb();
        test_stall();
        test_fmt_switch();
        test_clear_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
